// File: rtl/column_read_ctrl_pkg.sv
// Shared types and constants for the column readout controller.
// Broadcast bit map, FSM states and the column word width.
package column_read_ctrl_pkg;

  localparam int COL_W = 46;
  localparam int HIT_W = 5;

  localparam int BCST_RST  = 0;
  localparam int BCST_L1A  = 1;
  localparam int BCST_LOAD = 2;
  localparam int BCST_ADDR = 3;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SETTLE,
    READ,
    DONE
  } state_e;

endpackage

// File: rtl/column_read_ctrl_if.sv
// Valid/ready output word stream of the column readout controller.
// The master side produces words, the slave side consumes them.
interface column_read_ctrl_if #(
  parameter int W = 46
);

  logic [W-1:0] outData;
  logic         outValid;
  logic         outReady;

  modport master (
    output outData,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    output outReady
  );

endinterface

// File: rtl/column_out_fifo.sv
// First-word-fall-through FIFO between the column and the output stream.
// Pointers carry one extra wrap bit to tell full from empty.
module column_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                && (wptr_q[AW] != rptr_q[AW]);

  // A pop in the same cycle frees the slot, so push at full is allowed.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/column_read_ctrl.sv
// Trigger-driven readout of one pixel column into an output stream.
// Broadcasts L1A, waits for the column to settle, then drains its hits.
module column_read_ctrl
  import column_read_ctrl_pkg::*;
#(
  parameter int L1ADDRWIDTH = 7,
  parameter int BCSTWIDTH   = 27,
  parameter int SETTLE_CYC  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   l1aIn,
  input  logic [L1ADDRWIDTH-1:0] l1aAddrIn,
  input  logic                   loadIn,
  input  logic                   chainRstIn,
  input  logic [COL_W-1:0]       colData,
  input  logic [HIT_W-1:0]       colHits,
  output logic                   colRead,
  output logic [BCSTWIDTH-1:0]   colBCST,
  column_read_ctrl_if.master     ostr,
  output logic                   evtDone,
  output logic [HIT_W-1:0]       evtHitCnt,
  output logic                   busy,
  output logic                   l1aDropped
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SETTLE_CYC - 1);

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [L1ADDRWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [HIT_W-1:0]       rem_q, rem_d;
  logic [HIT_W-1:0]       ecnt_q, ecnt_d;
  logic [BCSTWIDTH-1:0]   bcst_q, bcst_d;
  logic [L1ADDRWIDTH-1:0] bc_addr;
  logic                   rd;
  logic                   drop;
  logic                   l1a_ok;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign l1a_ok = l1aIn && !chainRstIn;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    scnt_d      = scnt_q;
    rem_d       = rem_q;
    ecnt_d      = ecnt_q;
    bc_addr     = '0;
    rd          = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = BCAST;
          bc_addr = pend_addr_q;
          pend_d  = l1a_ok;
          if (l1a_ok) pend_addr_d = l1aAddrIn;
        end else if (l1a_ok) begin
          state_d = BCAST;
          bc_addr = l1aAddrIn;
        end
      end
      BCAST: begin
        state_d = SETTLE;
        scnt_d  = '0;
      end
      SETTLE: begin
        if (scnt_q == SCNT_LAST) begin
          rem_d   = colHits;
          ecnt_d  = colHits;
          state_d = (colHits == '0) ? DONE : READ;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      READ: begin
        if (rem_q != '0 && !fifo_full && colHits != '0) begin
          rd    = 1'b1;
          rem_d = rem_q - HIT_W'(1);
          if (rem_q == HIT_W'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // One trigger may wait behind the running event; a second is lost.
    if (state_q != IDLE && l1a_ok) begin
      if (pend_q) begin
        drop = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_addr_d = l1aAddrIn;
      end
    end

    if (chainRstIn) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      scnt_d  = '0;
      rem_d   = '0;
      ecnt_d  = '0;
      rd      = 1'b0;
      drop    = 1'b0;
    end

    bcst_d            = '0;
    bcst_d[BCST_RST]  = chainRstIn;
    bcst_d[BCST_LOAD] = loadIn;
    if (state_d == BCAST) begin
      bcst_d[BCST_L1A]                    = 1'b1;
      bcst_d[BCST_ADDR +: L1ADDRWIDTH]    = bc_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      scnt_q      <= '0;
      rem_q       <= '0;
      ecnt_q      <= '0;
      bcst_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      scnt_q      <= scnt_d;
      rem_q       <= rem_d;
      ecnt_q      <= ecnt_d;
      bcst_q      <= bcst_d;
    end
  end

  assign colRead    = rd && !reset;
  assign colBCST    = bcst_q;
  assign evtDone    = (state_q == DONE);
  assign evtHitCnt  = evtDone ? ecnt_q : '0;
  assign busy       = (state_q != IDLE);
  assign l1aDropped = drop && !reset;
  assign ostr.outValid = !fifo_empty;

  column_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (chainRstIn),
    .push_i  (colRead),
    .wdata_i (colData),
    .pop_i   (ostr.outValid && ostr.outReady),
    .rdata_o (ostr.outData),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_column_read_ctrl.sv
// Directed bench for column_read_ctrl with a show-ahead column model.
// Output words and column pops are logged at the clock edge.
module tb_column_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        l1aIn;
  logic [6:0]  l1aAddrIn;
  logic        loadIn;
  logic        chainRstIn;
  logic [45:0] colData;
  logic [4:0]  colHits;
  logic        colRead;
  logic [26:0] colBCST;
  logic        evtDone;
  logic [4:0]  evtHitCnt;
  logic        busy;
  logic        l1aDropped;

  column_read_ctrl_if #(.W(46)) oif ();

  column_read_ctrl #(
    .L1ADDRWIDTH (7),
    .BCSTWIDTH   (27),
    .SETTLE_CYC  (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .l1aIn      (l1aIn),
    .l1aAddrIn  (l1aAddrIn),
    .loadIn     (loadIn),
    .chainRstIn (chainRstIn),
    .colData    (colData),
    .colHits    (colHits),
    .colRead    (colRead),
    .colBCST    (colBCST),
    .ostr       (oif),
    .evtDone    (evtDone),
    .evtHitCnt  (evtHitCnt),
    .busy       (busy),
    .l1aDropped (l1aDropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [45:0] colMem [16];
  int          col_n = 0;
  int          col_rd = 0;
  logic        col_clr = 1'b0;

  assign colHits = 5'(col_n - col_rd);
  assign colData = (col_rd < col_n) ? colMem[col_rd[3:0]] : '0;

  logic [45:0] got [32];
  int          got_n = 0;
  int          rd_cnt = 0;
  int          viol = 0;
  logic        mon_clr = 1'b0;

  always @(posedge clk) begin
    if (col_clr) col_rd <= 0;
    else if (colRead) col_rd <= col_rd + 1;
    if (mon_clr) begin
      got_n  <= 0;
      rd_cnt <= 0;
      viol   <= 0;
    end else begin
      if (colRead) rd_cnt <= rd_cnt + 1;
      if (colRead && colHits == 5'd0) viol <= viol + 1;
      if (oif.outValid && oif.outReady && got_n < 32) begin
        got[got_n] <= oif.outData;
        got_n      <= got_n + 1;
      end
    end
  end

  function automatic logic [45:0] colw(int b, int i);
    return {14'h1A5, 16'(b), 16'(i)};
  endfunction

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic col_load(int n, int b);
    col_clr = 1'b1;
    col_n   = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) colMem[i] = colw(b, i);
    col_n   = n;
    col_clr = 1'b0;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_l1a(logic [6:0] a);
    l1aAddrIn = a;
    l1aIn     = 1'b1;
    @(negedge clk);
    l1aIn     = 1'b0;
  endtask

  task automatic wait_done(string tag, int lim, output logic [4:0] hc);
    int k;
    k  = 0;
    hc = 5'h1F;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (evtDone) begin
        k  = i;
        hc = evtHitCnt;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(k != 0), 64'd1);
  endtask

  logic [4:0] hc;
  int         first_rd;
  int         done_k;
  int         cnt_a;
  int         cnt_b;
  int         cnt_c;
  logic       seen;
  logic [6:0] seen_addr;

  initial begin
    reset      = 1'b1;
    l1aIn      = 1'b0;
    l1aAddrIn  = '0;
    loadIn     = 1'b0;
    chainRstIn = 1'b0;
    oif.outReady = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_bcst", 64'(colBCST), 0);
    chk("rst_valid", 64'(oif.outValid), 0);
    chk("rst_colread", 64'(colRead), 0);
    chk("rst_done", 64'(evtDone), 0);
    chk("rst_hitcnt", 64'(evtHitCnt), 0);
    chk("rst_drop", 64'(l1aDropped), 0);
    reset = 1'b0;

    // Basic event: 3 hits, address 2A
    col_load(3, 1);
    clr_mon();
    oif.outReady = 1'b1;
    l1aAddrIn = 7'h2A;
    l1aIn     = 1'b1;
    first_rd  = -1;
    done_k    = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        l1aIn = 1'b0;
        chk("t1_bc_l1a", 64'(colBCST[1]), 1);
        chk("t1_bc_addr", 64'(colBCST[9:3]), 64'h2A);
        chk("t1_busy", 64'(busy), 1);
      end
      if (k == 2) chk("t1_bc_l1a_off", 64'(colBCST[1]), 0);
      if (k == 17) chk("t1_rd_early", 64'(colRead), 0);
      if (colRead && first_rd < 0) first_rd = k;
      if (evtDone) begin
        done_k = k;
        hc     = evtHitCnt;
        break;
      end
    end
    chk("t1_first_rd", 64'(first_rd), 18);
    chk("t1_done_k", 64'(done_k), 21);
    chk("t1_hitcnt", 64'(hc), 3);
    @(negedge clk);
    chk("t1_idle", 64'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t1_rdcnt", 64'(rd_cnt), 3);
    chk("t1_gotn", 64'(got_n), 3);
    for (int i = 0; i < 3; i++) chk("t1_word", 64'(got[i]), 64'(colw(1, i)));

    // Empty column at sample time
    col_load(0, 2);
    clr_mon();
    pulse_l1a(7'h05);
    wait_done("t2", 40, hc);
    chk("t2_hitcnt", 64'(hc), 0);
    chk("t2_rdcnt", 64'(rd_cnt), 0);
    @(negedge clk);
    chk("t2_idle", 64'(busy), 0);

    // Back-pressure with a full column
    col_load(16, 3);
    clr_mon();
    oif.outReady = 1'b0;
    pulse_l1a(7'h10);
    repeat (30) @(negedge clk);
    chk("t3_rd_stall", 64'(rd_cnt), 4);
    chk("t3_valid", 64'(oif.outValid), 1);
    chk("t3_colread_off", 64'(colRead), 0);
    oif.outReady = 1'b1;
    wait_done("t3", 60, hc);
    chk("t3_hitcnt", 64'(hc), 16);
    repeat (4) @(negedge clk);
    chk("t3_gotn", 64'(got_n), 16);
    for (int i = 0; i < 16; i++) chk("t3_word", 64'(got[i]), 64'(colw(3, i)));
    chk("t3_viol", 64'(viol), 0);

    // Queued and dropped triggers
    col_load(2, 4);
    clr_mon();
    pulse_l1a(7'h11);
    repeat (2) @(negedge clk);
    l1aAddrIn = 7'h22;
    l1aIn     = 1'b1;
    #1 chk("t4_no_drop", 64'(l1aDropped), 0);
    @(negedge clk);
    l1aIn = 1'b0;
    @(negedge clk);
    l1aAddrIn = 7'h33;
    l1aIn     = 1'b1;
    #1 chk("t4_drop", 64'(l1aDropped), 1);
    @(negedge clk);
    l1aIn = 1'b0;
    #1 chk("t4_drop_off", 64'(l1aDropped), 0);
    wait_done("t4a", 40, hc);
    chk("t4a_hitcnt", 64'(hc), 2);
    col_load(1, 5);
    seen      = 1'b0;
    seen_addr = '0;
    for (int i = 0; i < 10; i++) begin
      if (colBCST[1]) begin
        seen      = 1'b1;
        seen_addr = colBCST[9:3];
        break;
      end
      @(negedge clk);
    end
    chk("t4_pend_bc", 64'(seen), 1);
    chk("t4_pend_addr", 64'(seen_addr), 64'h22);
    wait_done("t4b", 40, hc);
    chk("t4b_hitcnt", 64'(hc), 1);
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (colBCST[1] || busy) cnt_a++;
    end
    chk("t4_no_third", 64'(cnt_a), 0);

    // Chain reset mid-READ
    col_load(16, 6);
    clr_mon();
    oif.outReady = 1'b0;
    pulse_l1a(7'h33);
    repeat (25) @(negedge clk);
    chk("t5_valid_pre", 64'(oif.outValid), 1);
    chk("t5_busy_pre", 64'(busy), 1);
    chainRstIn = 1'b1;
    @(negedge clk);
    chainRstIn = 1'b0;
    chk("t5_bc_rst", 64'(colBCST[0]), 1);
    chk("t5_valid", 64'(oif.outValid), 0);
    chk("t5_idle", 64'(busy), 0);
    chk("t5_no_done", 64'(evtDone), 0);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (evtDone) cnt_a++;
      if (colBCST[0]) cnt_b++;
      if (colRead) cnt_c++;
    end
    chk("t5_done_cnt", 64'(cnt_a), 0);
    chk("t5_rst_len", 64'(cnt_b), 0);
    chk("t5_rd_after", 64'(cnt_c), 0);
    l1aAddrIn  = 7'h44;
    chainRstIn = 1'b1;
    l1aIn      = 1'b1;
    #1 chk("t5_prio_drop", 64'(l1aDropped), 0);
    @(negedge clk);
    chainRstIn = 1'b0;
    l1aIn      = 1'b0;
    chk("t5_prio_bc0", 64'(colBCST[0]), 1);
    chk("t5_prio_bc1", 64'(colBCST[1]), 0);
    @(negedge clk);
    chk("t5_prio_idle", 64'(busy), 0);
    chk("t5_prio_bc1b", 64'(colBCST[1]), 0);

    // Load and trigger together
    col_load(0, 7);
    l1aAddrIn = 7'h55;
    loadIn    = 1'b1;
    l1aIn     = 1'b1;
    @(negedge clk);
    loadIn = 1'b0;
    l1aIn  = 1'b0;
    chk("t6_load", 64'(colBCST[2]), 1);
    chk("t6_l1a", 64'(colBCST[1]), 1);
    chk("t6_addr", 64'(colBCST[9:3]), 64'h55);
    @(negedge clk);
    chk("t6_load_off", 64'(colBCST[2]), 0);
    chk("t6_l1a_off", 64'(colBCST[1]), 0);
    wait_done("t6", 40, hc);
    chk("t6_hitcnt", 64'(hc), 0);

    // Reset during READ
    col_load(16, 8);
    clr_mon();
    oif.outReady = 1'b0;
    pulse_l1a(7'h66);
    repeat (18) @(negedge clk);
    chk("t7_reading", 64'(colRead), 1);
    reset = 1'b1;
    #1 chk("t7_rd_gated", 64'(colRead), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t7_busy", 64'(busy), 0);
    chk("t7_valid", 64'(oif.outValid), 0);
    chk("t7_bcst", 64'(colBCST), 0);
    chk("t7_hitcnt", 64'(evtHitCnt), 0);
    @(negedge clk);
    chk("t7_still_idle", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/column_read_ctrl.md
COLUMN_READ_CTRL -- requirements
Module: column_read_ctrl

Interface
REQ-001 SHALL have parameter L1ADDRWIDTH, default 7: width of the L1A buffer address broadcast to the pixels.
REQ-002 SHALL have parameter BCSTWIDTH, default 27: width of the broadcast bus into the column.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: cycles waited after an L1A broadcast before the column hit count is sampled.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: depth of the output FIFO, a power of 2.
REQ-005 SHALL use one clock and a synchronous, active-high reset: `clk` input 1, the 40 MHz readout clock; `reset` input 1, the reset.
REQ-006 SHALL have the command inputs:
- `l1aIn` input 1: trigger pulse.
- `l1aAddrIn` input L1ADDRWIDTH: buffer address for the trigger.
- `loadIn` input 1: configuration-load pulse.
- `chainRstIn` input 1: column-chain reset request.
REQ-007 SHALL have the column-side ports:
- `colData` input 46: data word at the bottom of the column.
- `colHits` input 5: hits pending in the column, 0..16.
- `colRead` output 1: pop strobe to the column.
- `colBCST` output BCSTWIDTH: broadcast bus into the column.
REQ-008 SHALL have the output-side ports:
- `outData` output 46, `outValid` output 1, `outReady` input 1: valid/ready output stream.
- `evtDone` output 1: one-cycle end-of-event pulse.
- `evtHitCnt` output 5: hits read for the event, valid with `evtDone`.
- `busy` output 1: event in progress.
- `l1aDropped` output 1: one-cycle pulse when a trigger is lost.

Function
REQ-009 SHALL drive colBCST from registers with this field map: bit0 chain reset, bit1 L1A, bit2 load, bits[L1ADDRWIDTH+2:3] L1A address, all other bits 0.
REQ-010 SHALL, when loadIn is high in cycle N, raise colBCST bit2 for exactly cycle N+1, in any state.
REQ-011 SHALL use the FSM states IDLE, BCAST, SETTLE, READ and DONE.
REQ-012 SHALL, in IDLE, on l1aIn (or a pending trigger), go to BCAST; in BCAST, drive colBCST bit1=1 and the address field for one cycle.
REQ-013 SHALL, in SETTLE, count SETTLE_CYC cycles, then latch colHits into a remaining counter and an event counter.
- Latched count 0: go to DONE.
- Otherwise: go to READ.
REQ-014 SHALL, in READ, assert colRead in a cycle only when remaining>0 and the FIFO is not full.
- In that same cycle, write colData into the FIFO and decrement remaining.
- When remaining reaches 0, go to DONE.
REQ-015 SHALL, in DONE, pulse evtDone with evtHitCnt equal to the latched count for one cycle, then return to IDLE.
REQ-016 SHALL treat colData as show-ahead: the word is valid whenever colHits>0, and colRead pops it at the clock edge.
REQ-017 SHALL implement the FIFO as first-word-fall-through: outValid=!empty, outData=head, pop on outValid&&outReady.
- A simultaneous push and pop at full SHALL be allowed.
- Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 SHALL assert busy whenever the state is not IDLE.
REQ-019 SHALL handle a trigger arriving when the state is not IDLE as follows:
- No trigger pending: set a one-deep pending register holding the address.
- Trigger already pending: pulse l1aDropped and discard the new trigger.
REQ-020 SHALL, on chainRstIn:
- drive colBCST bit0=1 for the next cycle;
- flush the FIFO and clear pending and counters;
- force IDLE without an evtDone pulse.
chainRstIn SHALL take priority over a simultaneous l1aIn, and that trigger SHALL be discarded without an l1aDropped pulse.
REQ-021 SHALL ensure colRead is never high while colHits==0 and never high in a cycle where the FIFO is full with no pop.

Reset
REQ-022 SHALL, on reset, set the state to IDLE; colBCST, colRead, outValid, evtDone, l1aDropped and busy to 0; evtHitCnt to 0; and FIFO, pending and counters empty.
REQ-023 SHALL give reset priority over every input, including a reset applied mid-READ, and SHALL NOT drive colBCST bit0 as a result of reset.

Structure
REQ-024 SHALL keep in the shared package: the BCST bit indices, the FSM state enum, and the 46-bit column word width.
REQ-025 SHALL place the output FIFO in one sub-module, column_out_fifo, parameterised by depth and width.

Verification
REQ-026 SHALL cover: l1aIn with l1aAddrIn=7'h2A and colHits=3 -> colBCST bit1 high for one cycle with field 7'h2A, exactly 3 colRead pulses after 16 settle cycles, 3 words out in order, evtDone with evtHitCnt=3.
REQ-027 SHALL cover: colHits=0 at sample time -> no colRead, evtDone with evtHitCnt=0, busy low the following cycle.
REQ-028 SHALL cover: colHits=16 with outReady held low -> colRead stops after 4 words; raising outReady -> all 16 words delivered, no loss and no duplicates.
REQ-029 SHALL cover: three l1aIn pulses during one event -> second is queued and served next, third gives one l1aDropped pulse.
REQ-030 SHALL cover: chainRstIn mid-READ with words in the FIFO -> colBCST bit0 pulse, outValid low next cycle, IDLE, no evtDone.
REQ-031 SHALL cover: loadIn and l1aIn in the same cycle -> bit2 and the bit1 broadcast each appear, each for exactly one cycle.
